// File: rtl/dpram_stream_reader.sv
// Streams a block of words out of a latency-READ_LATENCY dual-port RAM read port
// onto a valid/ready stream; reads are only issued when buffer space is reserved.
module dpram_stream_reader #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  rden,
  input  logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_rden;
  logic [ADDR_WIDTH-1:0]   r_address;
  logic [ADDR_WIDTH-1:0]   r_next_addr;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_issued;
  logic [LEN_W-1:0]        r_beats;

  logic [READ_LATENCY-1:0] r_vsr;
  logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic                    r_out_valid;
  logic                    r_out_last;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_room;
  logic                    w_last_next;
  logic [SUM_W-1:0]        w_inflight;
  logic [SUM_W-1:0]        w_occupancy;
  logic [CNT_W-1:0]        w_count_next;
  logic [PTR_W-1:0]        w_rd_ptr_next;
  logic [LEN_W-1:0]        w_beats_next;
  logic [DATA_WIDTH-1:0]   w_head_next;

  // Occupancy = buffered words + reads still in the RAM pipeline (including the
  // one on rden this cycle); a new read is granted only if it keeps that <= depth.
  always_comb begin
    w_push     = r_vsr[READ_LATENCY-1];
    w_pop      = r_out_valid && out_ready;
    w_inflight = SUM_W'(r_rden);
    for (int i = 0; i < int'(READ_LATENCY); i++) begin
      w_inflight = w_inflight + SUM_W'(r_vsr[i]);
    end
    w_occupancy   = SUM_W'(r_count) + w_inflight - SUM_W'(w_pop);
    w_room        = w_occupancy < SUM_W'(FIFO_DEPTH);
    w_count_next  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    w_rd_ptr_next = r_rd_ptr + PTR_W'(w_pop);
    w_beats_next  = r_beats + LEN_W'(w_pop);
    // The next head is the word being written now when it lands at the new read pointer.
    w_head_next   = (w_push && (r_wr_ptr == w_rd_ptr_next)) ? q : r_mem[w_rd_ptr_next];
    w_last_next   = (w_count_next != '0) && (w_beats_next == (r_len - LEN_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= q;
    end
  end

  // Return-valid pipeline, buffer pointers and the registered stream head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vsr       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_vsr[0] <= r_rden;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        r_vsr[i] <= r_vsr[i-1];
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr    <= w_rd_ptr_next;
      r_count     <= w_count_next;
      r_out_valid <= (w_count_next != '0);
      r_out_last  <= w_last_next;
      if (w_count_next != '0) begin
        r_out_data <= w_head_next;
      end
    end
  end

  // Transfer control: latch the request, pace reads, close on the last beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rden      <= 1'b0;
      r_address   <= '0;
      r_next_addr <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_beats     <= '0;
    end else begin
      r_done  <= 1'b0;
      r_rden  <= 1'b0;
      r_beats <= w_beats_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (length != '0) begin
              r_state     <= S_READ;
              r_busy      <= 1'b1;
              r_rden      <= 1'b1;
              r_address   <= base_addr;
              r_next_addr <= base_addr + ADDR_WIDTH'(1);
              r_len       <= length;
              r_issued    <= LEN_W'(1);
              r_beats     <= '0;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (r_issued == r_len) begin
            r_state <= S_DRAIN;
          end else if (w_room) begin
            r_rden      <= 1'b1;
            r_address   <= r_next_addr;
            r_next_addr <= r_next_addr + ADDR_WIDTH'(1);
            r_issued    <= r_issued + LEN_W'(1);
          end
        end
        S_DRAIN: begin
          if (w_pop && r_out_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign address   = r_address;
  assign rden      = r_rden;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule

// File: doc/dpram_stream_reader.md
DPRAM_STREAM_READER -- requirements
Module: dpram_stream_reader

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; all logic SHALL be clocked on the rising edge of clk.
REQ-002 Parameter ADDR_WIDTH, default 10: width of the RAM word address.
REQ-003 Parameter DATA_WIDTH, default 32: width of the RAM word and of the stream data.
REQ-004 Parameter READ_LATENCY, default 1: cycles from rden high to valid q, with a legal range of 1..4.
REQ-005 Parameter FIFO_DEPTH, default 4: output buffer depth, a power of 2 that is at least READ_LATENCY+1.
REQ-006 Port clk, input, 1: clock for all logic.
REQ-007 Port reset_n, input, 1: asynchronous reset, active low.
REQ-008 Port start, input, 1: one-cycle request to begin a transfer.
REQ-009 Port base_addr, input, ADDR_WIDTH: first word address, sampled with start.
REQ-010 Port length, input, ADDR_WIDTH+1: number of words to read, sampled with start.
REQ-011 Port busy, output, 1: high while a transfer is in progress.
REQ-012 Port done, output, 1: one-cycle pulse at transfer completion.
REQ-013 Port address, output, ADDR_WIDTH: RAM read address.
REQ-014 Port rden, output, 1: RAM read enable, one word per high cycle.
REQ-015 Port q, input, DATA_WIDTH: RAM read data, valid READ_LATENCY cycles after rden.
REQ-016 Port out_data, output, DATA_WIDTH: stream data.
REQ-017 Port out_valid, output, 1: stream data valid.
REQ-018 Port out_ready, input, 1: stream sink ready.
REQ-019 Port out_last, output, 1: marks the final word of a transfer.

Function
REQ-020 States SHALL be IDLE, READ and DRAIN.
REQ-021 In IDLE, start with length>0 SHALL latch base_addr and length, assert busy from the next cycle and enter READ.
REQ-022 In IDLE, start with length==0 SHALL pulse done on the next cycle, leave busy low and remain in IDLE.
REQ-023 start SHALL be ignored while busy is high.
REQ-024 In READ, rden SHALL be asserted in a cycle only when issued<length and fifo_count+inflight<FIFO_DEPTH, where inflight is the number of reads not yet returned.
REQ-025 A read SHALL NOT be issued without guaranteed buffer space, so no returned word is ever dropped.
REQ-026 The address of read k SHALL be (base_addr+k) mod 2^ADDR_WIDTH, so it wraps from all-ones to 0.
REQ-027 q SHALL be captured into the FIFO exactly READ_LATENCY cycles after each rden using a READ_LATENCY-deep valid shift register; q SHALL be ignored in all other cycles.
REQ-028 The stream SHALL follow valid/ready: a beat transfers when out_valid && out_ready.
REQ-029 out_data, out_valid and out_last SHALL remain stable while out_valid && !out_ready.
REQ-030 out_valid SHALL be high whenever the FIFO is non-empty, and out_data SHALL be the FIFO head.
REQ-031 A simultaneous FIFO write and read SHALL leave fifo_count unchanged.
REQ-032 out_last SHALL be high only on the beat with index length-1.
REQ-033 The transition READ->DRAIN SHALL occur when issued==length.
REQ-034 The transition DRAIN->IDLE SHALL occur on the cycle the last beat transfers; done SHALL pulse one cycle later, and busy SHALL fall in the same cycle as done.
REQ-035 Best-case throughput SHALL be one word per cycle with out_ready held high.
REQ-036 First-word latency SHALL be start->rden 1 cycle, then rden->out_valid READ_LATENCY+1 cycles (FIFO write then read).
REQ-037 The maximum length of 2^ADDR_WIDTH SHALL read every address exactly once, wrapping as in REQ-026.

Reset
REQ-038 While reset_n is low, the block SHALL be in IDLE with busy=0, done=0, rden=0, address=0, out_valid=0, out_last=0, out_data=0, and the FIFO and inflight tracking cleared.
REQ-039 Reset asserted mid-transfer SHALL abandon the transfer immediately with no done pulse, and data returning after reset SHALL be discarded.
REQ-040 After reset_n deasserts, the block SHALL accept start on the first cycle.

Verification
REQ-041 Scenario: base_addr=0x010, length=4, out_ready=1, READ_LATENCY=1 -> rden high 4 consecutive cycles at addresses 0x010..0x013; beats equal mem[0x010..0x013]; out_last on the 4th beat; a single done pulse.
REQ-042 Scenario: base_addr=0x3FE, length=4, ADDR_WIDTH=10 -> addresses 0x3FE, 0x3FF, 0x000, 0x001, in order.
REQ-043 Scenario: length=16, out_ready=0 for 20 cycles then 1 -> at most FIFO_DEPTH reads outstanding+buffered, no rden while full, all 16 words delivered in order with none lost.
REQ-044 Scenario: length=0 -> no rden, busy stays 0, done pulses the cycle after start.
REQ-045 Scenario: start pulsed again while busy with a different base_addr -> ignored; the original transfer completes unchanged.
REQ-046 Scenario: reset_n low during DRAIN with 2 words buffered -> outputs at reset values, no done; a new transfer of length=2 then completes correctly.
